// File: rtl/alu_acc_ctrl_if.sv
// Command/response bus between the instruction sequencer and the accumulator controller.
interface alu_acc_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] acc_out;
    logic [3:0]       flags_out;

    // Sequencer side: issues commands, consumes responses.
    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, acc_out, flags_out
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, acc_out, flags_out
    );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Accumulator controller driving an external combinational add/sub ALU.
// Each command runs IDLE -> EXEC -> RESP; results are captured at the end of EXEC.
module alu_acc_ctrl #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_acc_ctrl_if.slave    bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    input  logic             alu_ovf,
    input  logic             alu_zero
);

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpLoad = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpSub  = 3'b011;
    localparam logic [2:0] OpCmp  = 3'b100;
    localparam logic [2:0] OpClrf = 3'b101;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;   // {C, V, Z, N}
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2:0]       op_q, op_d;
    logic             cmd_ready;
    logic             rsp_valid;
    logic             sub_op;

    // The ALU sees only registered values, so its inputs are stable through EXEC.
    assign alu_a  = acc_q;
    assign alu_b  = opnd_q;
    assign sub_op = (op_q == OpSub) || (op_q == OpCmp);

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.acc_out   = acc_q;
    assign bus.flags_out = flags_q;

    // State, accumulator, flags and latched command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= ACC_RST;
            flags_q <= '0;
            opnd_q  <= '0;
            op_q    <= OpNop;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
        end
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        flags_d   = flags_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_sub   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    opnd_d  = bus.cmd_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_sub = sub_op;
                state_d = StResp;
                case (op_q)
                    OpLoad: begin
                        acc_d   = opnd_q;
                        flags_d = {1'b0, 1'b0, (opnd_q == '0), opnd_q[WIDTH-1]};
                    end
                    OpAdd, OpSub: begin
                        acc_d   = alu_sum;
                        flags_d = {alu_cout, alu_ovf, alu_zero, alu_sum[WIDTH-1]};
                    end
                    OpCmp: begin
                        flags_d = {alu_cout, alu_ovf, alu_zero, alu_sum[WIDTH-1]};
                    end
                    OpClrf: begin
                        flags_d = '0;
                    end
                    // NOP and reserved codes still produce a response.
                    default: ;
                endcase
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Self-checking bench for alu_acc_ctrl with a behavioural ALU and reference model.
module tb_alu_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_sum;
    logic       alu_sub, alu_cout, alu_ovf, alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_acc   = 8'h00;
    logic [3:0] m_flags = 4'h0;

    alu_acc_ctrl_if #(.WIDTH(8)) bus ();

    alu_acc_ctrl #(.WIDTH(8), .ACC_RST(8'h00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sub  (alu_sub),
        .alu_sum  (alu_sum),
        .alu_cout (alu_cout),
        .alu_ovf  (alu_ovf),
        .alu_zero (alu_zero)
    );

    always #5 clk = ~clk;

    // Combinational 8-bit add/sub ALU; Cout is borrow on subtract.
    logic [8:0] alu_raw;
    always_comb begin
        if (alu_sub) alu_raw = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        else         alu_raw = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_sum  = alu_raw[7:0];
    assign alu_cout = alu_sub ? ~alu_raw[8] : alu_raw[8];
    assign alu_ovf  = alu_sub ? ((alu_a[7] != alu_b[7]) && (alu_sum[7] != alu_a[7]))
                              : ((alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]));
    assign alu_zero = (alu_sum == 8'h00);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: architectural effect of one command using plain integer arithmetic.
    task automatic model_apply(input logic [2:0] op, input logic [7:0] d);
        int u, s;
        logic [7:0] r;
        case (op)
            3'd1: begin
                m_acc   = d;
                m_flags = {1'b0, 1'b0, d == 8'h00, d[7]};
            end
            3'd2: begin
                u = int'(m_acc) + int'(d);
                s = int'($signed(m_acc)) + int'($signed(d));
                r = u[7:0];
                m_flags = {u > 255, (s > 127) || (s < -128), r == 8'h00, r[7]};
                m_acc   = r;
            end
            3'd3, 3'd4: begin
                u = int'(m_acc) - int'(d);
                s = int'($signed(m_acc)) - int'($signed(d));
                r = u[7:0];
                m_flags = {m_acc < d, (s > 127) || (s < -128), r == 8'h00, r[7]};
                if (op == 3'd3) m_acc = r;
            end
            3'd5: m_flags = 4'h0;
            default: ;
        endcase
    endtask

    // Issue one command, hold the response for `hold` cycles, then handshake.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input int hold,
                           output logic [7:0] got_acc, output logic [3:0] got_flags);
        logic [7:0] pre_acc;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8 && !bus.cmd_ready; i++) @(negedge clk);
        check("cmd_ready_before_accept", bus.cmd_ready, 1);
        pre_acc = m_acc;
        @(negedge clk);  // EXEC cycle
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_data  = 8'($urandom);
        check("exec_rsp_valid", bus.rsp_valid, 0);
        check("exec_cmd_ready", bus.cmd_ready, 0);
        check("exec_alu_sub", alu_sub, (op == 3'd3 || op == 3'd4));
        check("exec_alu_a", alu_a, pre_acc);
        check("exec_alu_b", alu_b, d);
        model_apply(op, d);
        @(negedge clk);  // first RESP cycle
        check("resp_valid", bus.rsp_valid, 1);
        check("resp_alu_sub", alu_sub, 0);
        check("resp_acc", bus.acc_out, m_acc);
        check("resp_flags", bus.flags_out, m_flags);
        got_acc   = bus.acc_out;
        got_flags = bus.flags_out;
        for (int i = 0; i < hold; i++) begin
            // A competing command must be ignored while the response is pending.
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 3'd1;
            bus.cmd_data  = ~m_acc;
            @(negedge clk);
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            check("hold_acc", bus.acc_out, m_acc);
            check("hold_flags", bus.flags_out, m_flags);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_cmd_ready", bus.cmd_ready, 1);
        check("post_acc", bus.acc_out, m_acc);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] exp_acc;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0] ga;
        logic [3:0] gf;

        vecs[0]  = '{3'd1, 8'h7F, 8'h7F, 4'b0000};  // LOAD 7F
        vecs[1]  = '{3'd2, 8'h01, 8'h80, 4'b0101};  // ADD 01: signed overflow
        vecs[2]  = '{3'd1, 8'h00, 8'h00, 4'b0010};  // LOAD 00
        vecs[3]  = '{3'd3, 8'h01, 8'hFF, 4'b1001};  // SUB 01: borrow
        vecs[4]  = '{3'd2, 8'h01, 8'h00, 4'b1010};  // ADD 01: carry, zero
        vecs[5]  = '{3'd1, 8'h80, 8'h80, 4'b0001};  // LOAD 80
        vecs[6]  = '{3'd4, 8'h80, 8'h80, 4'b0010};  // CMP 80: equal
        vecs[7]  = '{3'd5, 8'hAA, 8'h80, 4'b0000};  // CLRF
        vecs[8]  = '{3'd0, 8'h33, 8'h80, 4'b0000};  // NOP
        vecs[9]  = '{3'd1, 8'h05, 8'h05, 4'b0000};  // LOAD 05
        vecs[10] = '{3'd3, 8'h07, 8'hFE, 4'b1001};  // SUB 07
        vecs[11] = '{3'd6, 8'h12, 8'hFE, 4'b1001};  // reserved: no change
        vecs[12] = '{3'd4, 8'h01, 8'hFE, 4'b0001};  // CMP 01: acc kept

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_acc", bus.acc_out, 8'h00);
        check("rst_flags", bus.flags_out, 4'h0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_alu_sub", alu_sub, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_alu_b", alu_b, 8'h00);

        // Directed table; vector 1 also exercises 5 cycles of backpressure.
        foreach (vecs[i]) begin
            run_cmd(vecs[i].op, vecs[i].data, (i == 1) ? 5 : 0, ga, gf);
            check($sformatf("vec%0d_acc", i), ga, vecs[i].exp_acc);
            check($sformatf("vec%0d_flags", i), gf, vecs[i].exp_flags);
        end

        // Reset during EXEC of ADD 05 with acc=10 aborts the update.
        run_cmd(3'd1, 8'h10, 0, ga, gf);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        bus.cmd_data  = 8'h05;
        for (int i = 0; i < 8 && !bus.cmd_ready; i++) @(negedge clk);
        check("rstx_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("rstx_in_exec", alu_sub, 0);
        check("rstx_exec_b", alu_b, 8'h05);
        rst_n = 1'b0;
        #1;
        check("rstx_acc", bus.acc_out, 8'h00);
        check("rstx_flags", bus.flags_out, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstx_no_rsp", bus.rsp_valid, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstx_idle_no_rsp", bus.rsp_valid, 0);
            check("rstx_idle_ready", bus.cmd_ready, 1);
            check("rstx_idle_acc", bus.acc_out, 8'h00);
        end
        m_acc   = 8'h00;
        m_flags = 4'h0;

        // Randomized commands against the reference model.
        for (int i = 0; i < 200; i++) begin
            run_cmd(3'($urandom_range(7, 0)), 8'($urandom), int'($urandom_range(3, 0)), ga, gf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
